cpu_ctrl: RTL and testbench

CPU_CTRL -- requirements
Module: cpu_ctrl

---
 rtl/cpu_ctrl_pkg.sv | 22 ++
 rtl/cpu_ctrl_if.sv | 25 ++
 rtl/cpu_ctrl_decode.sv | 27 ++
 rtl/cpu_ctrl.sv | 100 ++++++++++
 tb/tb_cpu_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the tiny two-register controller: widths, opcodes, FSM states.
package cpu_ctrl_pkg;

  localparam int REG_W = 3;
  localparam int PC_W  = 4;
  localparam int OP_W  = 4;
  localparam int INS_W = OP_W + REG_W;

  localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] OP_MOVA = 4'b0001;
  localparam logic [OP_W-1:0] OP_MOVB = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0111;
  localparam logic [OP_W-1:0] OP_HLT  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Instruction-memory handshake plus the operand/result bus to the combinational execution units.
interface cpu_ctrl_if;
  import cpu_ctrl_pkg::*;

  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [INS_W-1:0] imem_data;
  logic [OP_W-1:0]  kop;
  logic [REG_W-1:0] ax;
  logic [REG_W-1:0] bx;
  logic [REG_W-1:0] axx;
  logic [REG_W-1:0] bxx;

  modport master (
    output imem_req, imem_addr, kop, ax, bx,
    input  imem_ack, imem_data, axx, bxx
  );

  modport slave (
    input  imem_req, imem_addr, kop, ax, bx,
    output imem_ack, imem_data, axx, bxx
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Opcode decode: which register update an EXEC cycle performs, or whether it halts.
module cpu_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output logic            ld_ax_imm,
  output logic            ld_bx_imm,
  output logic            wb_ext,
  output logic            halt
);

  // Anything not explicitly known is handed to the external units for writeback.
  always_comb begin
    ld_ax_imm = 1'b0;
    ld_bx_imm = 1'b0;
    wb_ext    = 1'b0;
    halt      = 1'b0;
    case (opcode)
      OP_NOP:  ;
      OP_MOVA: ld_ax_imm = 1'b1;
      OP_MOVB: ld_bx_imm = 1'b1;
      OP_HLT:  halt      = 1'b1;
      default: wb_ext    = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Fetch/execute controller: FSM, program counter, instruction register and the AX/BX registers.
module cpu_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  cpu_ctrl_if.master      bus,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted
);

  state_t           state;
  logic [INS_W-1:0] ir;
  logic [REG_W-1:0] ax;
  logic [REG_W-1:0] bx;
  logic             req;
  logic [OP_W-1:0]  kop;
  logic             ld_ax_imm;
  logic             ld_bx_imm;
  logic             wb_ext;
  logic             halt;

  cpu_decode u_decode (
    .opcode    (ir[INS_W-1:REG_W]),
    .ld_ax_imm (ld_ax_imm),
    .ld_bx_imm (ld_bx_imm),
    .wb_ext    (wb_ext),
    .halt      (halt)
  );

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.kop       = kop;
  assign bus.ax        = ax;
  assign bus.bx        = bx;

  // Outputs are registered and set on entry to each state, so kop is non-zero only during EXEC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      ir     <= '0;
      ax     <= '0;
      bx     <= '0;
      req    <= 1'b0;
      kop    <= '0;
      busy   <= 1'b0;
      halted <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            req   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir    <= bus.imem_data;
            pc    <= pc + PC_W'(1);
            kop   <= bus.imem_data[INS_W-1:REG_W];
            req   <= 1'b0;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          kop <= '0;
          if (ld_ax_imm) ax <= ir[REG_W-1:0];
          if (ld_bx_imm) bx <= ir[REG_W-1:0];
          if (wb_ext) begin
            ax <= bus.axx;
            bx <= bus.bxx;
          end
          if (halt) begin
            state  <= S_HALT;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state <= S_FETCH;
            req   <= 1'b1;
          end
        end
        S_HALT: begin
          if (start) begin
            pc     <= '0;
            state  <= S_FETCH;
            req    <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: instruction memory responder, combinational exec unit, scoreboard.
module tb_cpu_ctrl;
  import cpu_ctrl_pkg::*;

  typedef struct {
    logic [REG_W-1:0] ax;
    logic [REG_W-1:0] bx;
    logic             halted;
    logic [PC_W-1:0]  pc;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             halted;

  logic [INS_W-1:0] mem [16];
  logic             forceEn;
  logic [REG_W-1:0] forceAx;
  logic [REG_W-1:0] forceBx;

  logic [PC_W-1:0]  modelPc;
  logic [REG_W-1:0] modelAx;
  logic [REG_W-1:0] modelBx;
  logic             modelHalted;
  exp_t             sbq [$];

  int checks;
  int errors;

  cpu_ctrl_if bus ();

  cpu_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bus    (bus),
    .pc     (pc),
    .busy   (busy),
    .halted (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Execution unit: real AND for 0111, otherwise a forced or pass-through result.
  always_comb begin
    if (bus.kop == OP_AND) begin
      bus.axx = bus.ax & bus.bx;
      bus.bxx = bus.bx;
    end else if (forceEn) begin
      bus.axx = forceAx;
      bus.bxx = forceBx;
    end else begin
      bus.axx = bus.ax;
      bus.bxx = bus.bx;
    end
  end

  function automatic logic [INS_W-1:0] ins(input logic [OP_W-1:0] op, input logic [REG_W-1:0] imm);
    return {op, imm};
  endfunction

  task automatic start_run();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    modelPc     = '0;
    modelHalted = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.imem_req !== 1'b1 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_state busy=%b req=%b halted=%b want 1 1 0", busy, bus.imem_req, halted);
    end
    checks++;
    if (bus.imem_addr !== 4'd0 || pc !== 4'd0) begin
      errors++;
      $display("[TB] FAIL start_addr addr=%0d pc=%0d want 0", bus.imem_addr, pc);
    end
    checks++;
    if (bus.ax !== modelAx || bus.bx !== modelBx) begin
      errors++;
      $display("[TB] FAIL start_regs ax=%0d bx=%0d want %0d %0d", bus.ax, bus.bx, modelAx, modelBx);
    end
  endtask

  task automatic do_instr(input int delay, input bit pulseStart);
    logic [INS_W-1:0] word;
    logic [OP_W-1:0]  op;
    logic [REG_W-1:0] imm;
    logic [REG_W-1:0] euAx;
    logic [REG_W-1:0] euBx;
    exp_t             e;
    int               w;
    w = 0;
    while (bus.imem_req !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (bus.imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL fetch_timeout req=%b want 1", bus.imem_req);
      return;
    end
    checks++;
    if (bus.imem_addr !== modelPc) begin
      errors++;
      $display("[TB] FAIL fetch_addr addr=%0d want %0d", bus.imem_addr, modelPc);
    end
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== modelPc || pc !== modelPc) begin
        errors++;
        $display("[TB] FAIL fetch_hold req=%b addr=%0d pc=%0d want 1 %0d %0d", bus.imem_req, bus.imem_addr, pc, modelPc, modelPc);
      end
    end
    word = mem[modelPc];
    op   = word[INS_W-1:REG_W];
    imm  = word[REG_W-1:0];
    bus.imem_ack  = 1'b1;
    bus.imem_data = word;
    euAx = (op == OP_AND) ? (modelAx & modelBx) : (forceEn ? forceAx : modelAx);
    euBx = (op == OP_AND) ? modelBx : (forceEn ? forceBx : modelBx);
    modelPc = modelPc + 4'd1;
    case (op)
      OP_NOP:  ;
      OP_MOVA: modelAx = imm;
      OP_MOVB: modelBx = imm;
      OP_HLT:  modelHalted = 1'b1;
      default: begin
        modelAx = euAx;
        modelBx = euBx;
      end
    endcase
    e.ax = modelAx;
    e.bx = modelBx;
    e.halted = modelHalted;
    e.pc = modelPc;
    sbq.push_back(e);
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    if (pulseStart) start = 1'b1;
    checks++;
    if (bus.kop !== op) begin
      errors++;
      $display("[TB] FAIL kop_exec kop=%b want %b", bus.kop, op);
    end
    checks++;
    if (pc !== modelPc || busy !== 1'b1 || bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL exec_state pc=%0d busy=%b req=%b want %0d 1 0", pc, busy, bus.imem_req, modelPc);
    end
    @(negedge clk);
    start = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (bus.ax !== e.ax || bus.bx !== e.bx) begin
      errors++;
      $display("[TB] FAIL exec_regs ax=%0d bx=%0d want %0d %0d", bus.ax, bus.bx, e.ax, e.bx);
    end
    checks++;
    if (halted !== e.halted || pc !== e.pc || bus.imem_req !== !e.halted) begin
      errors++;
      $display("[TB] FAIL post_exec halted=%b pc=%0d req=%b want %b %0d %b", halted, pc, bus.imem_req, e.halted, e.pc, !e.halted);
    end
    checks++;
    if (bus.kop !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL kop_after kop=%b want 0000", bus.kop);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.imem_req !== 1'b0 || bus.kop !== 4'b0000 || busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl req=%b kop=%b busy=%b halted=%b want 0 0000 0 0", bus.imem_req, bus.kop, busy, halted);
    end
    checks++;
    if (pc !== 4'd0 || bus.ax !== 3'd0 || bus.bx !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_regs pc=%0d ax=%0d bx=%0d want 0 0 0", pc, bus.ax, bus.bx);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.imem_req !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_hold busy=%b req=%b halted=%b want 0 0 0", busy, bus.imem_req, halted);
    end
  endtask

  task automatic test_program();
    mem[0] = ins(OP_MOVA, 3'd5);
    mem[1] = ins(OP_MOVB, 3'd3);
    mem[2] = ins(OP_AND, 3'd0);
    mem[3] = ins(OP_HLT, 3'd0);
    start_run();
    for (int i = 0; i < 4; i++) do_instr(0, 1'b0);
    checks++;
    if (bus.ax !== 3'd1 || bus.bx !== 3'd3 || halted !== 1'b1 || pc !== 4'd4) begin
      errors++;
      $display("[TB] FAIL program_end ax=%0d bx=%0d halted=%b pc=%0d want 1 3 1 4", bus.ax, bus.bx, halted, pc);
    end
  endtask

  task automatic test_halt_restart();
    mem[0] = ins(OP_MOVA, 3'd7);
    mem[1] = ins(OP_HLT, 3'd0);
    start_run();
    do_instr(0, 1'b0);
    do_instr(0, 1'b0);
    mem[0] = ins(OP_NOP, 3'd0);
    start_run();
    do_instr(0, 1'b1);
    do_instr(0, 1'b0);
    checks++;
    if (bus.ax !== 3'd7 || halted !== 1'b1 || pc !== 4'd2) begin
      errors++;
      $display("[TB] FAIL restart_end ax=%0d halted=%b pc=%0d want 7 1 2", bus.ax, halted, pc);
    end
  endtask

  task automatic test_delayed_ack();
    bus.imem_ack  = 1'b1;
    bus.imem_data = ins(OP_MOVA, 3'd1);
    repeat (3) @(negedge clk);
    bus.imem_ack  = 1'b0;
    checks++;
    if (halted !== 1'b1 || pc !== modelPc || bus.ax !== modelAx || bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_in_halt halted=%b pc=%0d ax=%0d req=%b want 1 %0d %0d 0", halted, pc, bus.ax, bus.imem_req, modelPc, modelAx);
    end
    mem[0] = ins(OP_MOVB, 3'd6);
    mem[1] = ins(OP_HLT, 3'd0);
    start_run();
    do_instr(3, 1'b0);
    do_instr(2, 1'b0);
  endtask

  task automatic test_unknown_op();
    mem[0] = ins(4'b0101, 3'd0);
    mem[1] = ins(OP_HLT, 3'd0);
    forceEn = 1'b1;
    forceAx = 3'd6;
    forceBx = 3'd2;
    start_run();
    do_instr(0, 1'b0);
    forceEn = 1'b0;
    do_instr(0, 1'b0);
    checks++;
    if (bus.ax !== 3'd6 || bus.bx !== 3'd2) begin
      errors++;
      $display("[TB] FAIL unknown_op ax=%0d bx=%0d want 6 2", bus.ax, bus.bx);
    end
  endtask

  task automatic test_pc_wrap();
    for (int i = 0; i < 16; i++) mem[i] = ins(OP_NOP, 3'd0);
    start_run();
    do_instr(0, 1'b0);
    mem[0] = ins(OP_HLT, 3'd0);
    for (int i = 1; i < 16; i++) do_instr(0, 1'b0);
    checks++;
    if (pc !== 4'd0 || bus.imem_addr !== 4'd0 || bus.imem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pc_wrap pc=%0d addr=%0d req=%b want 0 0 1", pc, bus.imem_addr, bus.imem_req);
    end
    do_instr(0, 1'b0);
  endtask

  task automatic test_reset_mid_fetch();
    mem[0] = ins(OP_MOVA, 3'd3);
    start_run();
    rst = 1'b1;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0 || busy !== 1'b0 || pc !== 4'd0 || bus.ax !== 3'd0) begin
      errors++;
      $display("[TB] FAIL async_reset req=%b busy=%b pc=%0d ax=%0d want 0 0 0 0", bus.imem_req, busy, pc, bus.ax);
    end
    #2;
    rst = 1'b0;
    bus.imem_ack  = 1'b1;
    bus.imem_data = mem[0];
    @(negedge clk);
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    modelAx = '0;
    modelBx = '0;
    modelPc = '0;
    checks++;
    if (busy !== 1'b0 || bus.imem_req !== 1'b0 || pc !== 4'd0 || bus.kop !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL late_ack busy=%b req=%b pc=%0d kop=%b want 0 0 0 0000", busy, bus.imem_req, pc, bus.kop);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ax !== 3'd0 || bus.bx !== 3'd0 || halted !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset ax=%0d bx=%0d halted=%b busy=%b want 0 0 0 0", bus.ax, bus.bx, halted, busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    start         = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = '0;
    forceEn       = 1'b0;
    forceAx       = '0;
    forceBx       = '0;
    modelPc       = '0;
    modelAx       = '0;
    modelBx       = '0;
    modelHalted   = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_program();
    test_halt_restart();
    test_delayed_ack();
    test_unknown_op();
    test_pc_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
